// File: rtl/npc_pkg.sv
// Shared encodings for the NPC core sequencer: state enum, PC/adder mux selects
// and the machine-mode trap cause codes.
package npc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_COMMIT,
        ST_HALT
    } seq_state_t;

    localparam logic [1:0] PC_SEL_ADDER = 2'b00;
    localparam logic [1:0] PC_SEL_MTVEC = 2'b01;
    localparam logic [1:0] PC_SEL_MEPC  = 2'b11;

    // bit1 picks adder A (rs1 vs pc), bit0 picks adder B (imm vs 4)
    localparam logic [1:0] ADDER_SEL_PC_4    = 2'b00;
    localparam logic [1:0] ADDER_SEL_PC_IMM  = 2'b01;
    localparam logic [1:0] ADDER_SEL_RS1_IMM = 2'b11;

    localparam logic [3:0] CAUSE_IFETCH  = 4'd1;
    localparam logic [3:0] CAUSE_LOAD    = 4'd4;
    localparam logic [3:0] CAUSE_STORE   = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

    function automatic logic [3:0] lsu_cause(input logic store);
        return store ? CAUSE_STORE : CAUSE_LOAD;
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_fetch_timeout_cnt.sv
// Cycle counter for the fetch watchdog: clear has priority over load, load over increment.
module fetch_timeout_cnt #(
    parameter int           W      = 16,
    parameter logic [W-1:0] TC_VAL = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle fetch/execute/memory/commit sequencer driving the PC unit, IMEM,
// LSU, register file and CSR trap path of the NPC core.
module pc_seq_ctrl
    import npc_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 255,
    parameter int CNT_W         = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic             imem_err,
    output logic             inst_we,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic             is_branch,
    input  logic             branch_taken,
    input  logic             is_ecall,
    input  logic             is_mret,
    input  logic             is_ebreak,
    input  logic             writes_rd,
    output logic             lsu_req,
    input  logic             lsu_done,
    input  logic             lsu_err,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [1:0]       adder_sel,
    output logic             rf_we,
    output logic             trap_we,
    output logic [3:0]       mcause_val,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    localparam logic [15:0] TO_TC = 16'(FETCH_TIMEOUT - 1);

    seq_state_t state;
    logic       fault;
    logic [3:0] cause;
    logic       to_tc;
    logic       in_fetch;

    assign in_fetch = (state == ST_FETCH);

    // Cleared on every exit from FETCH so each fetch gets the full window.
    fetch_timeout_cnt #(
        .W      (16),
        .TC_VAL (TO_TC)
    ) u_to_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (!in_fetch || imem_ack || to_tc),
        .load     (1'b0),
        .load_val ('0),
        .inc      (in_fetch),
        .tc       (to_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            fault   <= 1'b0;
            cause   <= '0;
            instret <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    // ack beats a coincident timeout
                    if (imem_ack) begin
                        if (imem_err) begin
                            fault <= 1'b1;
                            cause <= CAUSE_IFETCH;
                            state <= ST_COMMIT;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end else if (to_tc) begin
                        fault <= 1'b1;
                        cause <= CAUSE_IFETCH;
                        state <= ST_COMMIT;
                    end
                end
                ST_EXEC:
                    state <= (is_load || is_store) ? ST_MEM : ST_COMMIT;
                ST_MEM: begin
                    if (lsu_done) begin
                        if (lsu_err) begin
                            fault <= 1'b1;
                            cause <= lsu_cause(is_store && !is_load);
                        end
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    fault <= 1'b0;
                    cause <= '0;
                    if (!fault)
                        instret <= instret + CNT_W'(1);
                    state <= (!fault && !is_ecall && is_ebreak) ? ST_HALT : ST_FETCH;
                end
                ST_HALT:
                    state <= ST_HALT;
                default:
                    state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        inst_we    = 1'b0;
        lsu_req    = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PC_SEL_ADDER;
        adder_sel  = ADDER_SEL_PC_4;
        rf_we      = 1'b0;
        trap_we    = 1'b0;
        mcause_val = cause;
        halted     = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    inst_we  = imem_ack && !imem_err;
                end
                ST_EXEC:
                    lsu_req = is_load || is_store;
                ST_COMMIT: begin
                    if (fault) begin
                        pc_we   = 1'b1;
                        pc_sel  = PC_SEL_MTVEC;
                        trap_we = 1'b1;
                    end else if (is_ecall) begin
                        pc_we      = 1'b1;
                        pc_sel     = PC_SEL_MTVEC;
                        trap_we    = 1'b1;
                        mcause_val = CAUSE_ECALL_M;
                    end else if (is_ebreak) begin
                        rf_we = writes_rd;
                    end else begin
                        pc_we = 1'b1;
                        rf_we = writes_rd;
                        if (is_mret)
                            pc_sel = PC_SEL_MEPC;
                        else if (is_jalr)
                            adder_sel = ADDER_SEL_RS1_IMM;
                        else if (is_jal || (is_branch && branch_taken))
                            adder_sel = ADDER_SEL_PC_IMM;
                    end
                end
                ST_HALT:
                    halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: an instruction-level model builds the expected
// per-cycle outputs, one negedge process compares them and a few literal pins.
module tb_pc_seq_ctrl;

    localparam int FT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ack = 0, imem_err = 0;
    logic        is_load = 0, is_store = 0, is_jal = 0, is_jalr = 0;
    logic        is_branch = 0, branch_taken = 0, is_ecall = 0, is_mret = 0;
    logic        is_ebreak = 0, writes_rd = 0, lsu_done = 0, lsu_err = 0;
    logic        imem_req, inst_we, lsu_req, pc_we, rf_we, trap_we, halted;
    logic [1:0]  pc_sel, adder_sel;
    logic [3:0]  mcause_val;
    logic [63:0] instret;

    pc_seq_ctrl #(.FETCH_TIMEOUT(FT), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .imem_err(imem_err),
        .inst_we(inst_we), .is_load(is_load), .is_store(is_store), .is_jal(is_jal),
        .is_jalr(is_jalr), .is_branch(is_branch), .branch_taken(branch_taken),
        .is_ecall(is_ecall), .is_mret(is_mret), .is_ebreak(is_ebreak), .writes_rd(writes_rd),
        .lsu_req(lsu_req), .lsu_done(lsu_done), .lsu_err(lsu_err), .pc_we(pc_we),
        .pc_sel(pc_sel), .adder_sel(adder_sel), .rf_we(rf_we), .trap_we(trap_we),
        .mcause_val(mcause_val), .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req, iwe, lreq, pcwe;
        logic [1:0]  psel, asel;
        logic        rfwe, twe;
        logic [3:0]  cause;
        logic        halted, chk_ir;
        logic [63:0] ir;
    } exp_t;

    typedef struct {
        bit ld, st, jal, jalr, br, tk, ecall, mret, ebreak, wrd;
        int ack_dly;
        bit ack_err;
        int lsu_dly;
        bit lsu_err;
        int abort_mem;
    } instr_t;

    typedef enum {L_REQ, L_INSTRET, L_REQ_CNT, L_LSU_CNT, L_CAUSE, L_PCWE_CYC, L_HALTED} lsel_t;
    typedef struct {
        lsel_t       sel;
        logic [63:0] exp;
        int          at_n;
        string       name;
    } lit_t;

    int          n_chk = 0, n_fail = 0, ncnt = 0;
    int          cyc = 0, cnt_req = 0, cnt_lsu = 0, pcwe_cyc = 0;
    logic [3:0]  last_cause = 0;
    logic [63:0] m_ir = 0;
    exp_t        exp_q[$];
    lit_t        lit_q[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] lit_val(lsel_t s);
        case (s)
            L_REQ:      return 64'(imem_req);
            L_INSTRET:  return instret;
            L_REQ_CNT:  return 64'(cnt_req);
            L_LSU_CNT:  return 64'(cnt_lsu);
            L_CAUSE:    return 64'(last_cause);
            L_PCWE_CYC: return 64'(pcwe_cyc);
            default:    return 64'(halted);
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   i;
        ncnt++;
        if (rst) cyc = 0;
        else begin
            cyc++;
            if (imem_req) cnt_req++;
            if (lsu_req) cnt_lsu++;
            if (trap_we) last_cause = mcause_val;
            if (pc_we) pcwe_cyc = cyc;
        end
        i = 0;
        while (i < lit_q.size()) begin
            if (lit_q[i].at_n <= ncnt) begin
                chk(lit_q[i].name, lit_val(lit_q[i].sel), lit_q[i].exp);
                lit_q.delete(i);
            end else i++;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("imem_req", 64'(imem_req), 64'(e.req));
            chk("inst_we", 64'(inst_we), 64'(e.iwe));
            chk("lsu_req", 64'(lsu_req), 64'(e.lreq));
            chk("pc_we", 64'(pc_we), 64'(e.pcwe));
            chk("pc_sel", 64'(pc_sel), 64'(e.psel));
            chk("adder_sel", 64'(adder_sel), 64'(e.asel));
            chk("rf_we", 64'(rf_we), 64'(e.rfwe));
            chk("trap_we", 64'(trap_we), 64'(e.twe));
            chk("halted", 64'(halted), 64'(e.halted));
            if (e.twe) chk("mcause_val", 64'(mcause_val), 64'(e.cause));
            if (e.chk_ir) chk("instret", instret, e.ir);
        end
    end

    task automatic cyc_begin();
        @(posedge clk);
        #1;
        rst = 0; imem_ack = 0; imem_err = 0; lsu_done = 0; lsu_err = 0;
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e = '{default: '0};
        e.chk_ir = 1'b1;
        e.ir = m_ir;
        return e;
    endfunction

    function automatic instr_t nop();
        instr_t d;
        d = '{default: 0};
        return d;
    endfunction

    task automatic lit(lsel_t s, logic [63:0] v, int dly, string nm);
        lit_t l;
        l.sel = s; l.exp = v; l.at_n = ncnt + 1 + dly; l.name = nm;
        lit_q.push_back(l);
    endtask

    task automatic set_flags(instr_t d);
        is_load = d.ld; is_store = d.st; is_jal = d.jal; is_jalr = d.jalr;
        is_branch = d.br; branch_taken = d.tk; is_ecall = d.ecall;
        is_mret = d.mret; is_ebreak = d.ebreak; writes_rd = d.wrd;
    endtask

    task automatic do_reset(int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            cyc_begin();
            rst = 1;
            e = '{default: '0};
            e.chk_ir = (i > 0);
            e.ir = 0;
            exp_q.push_back(e);
        end
        m_ir = 0;
    endtask

    task automatic halt_cycles(int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            cyc_begin();
            imem_ack = i[0];
            lsu_done = i[1];
            e = idle_exp();
            e.halted = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // One instruction: fetch wait, optional EXEC/MEM, then the commit decision.
    task automatic run(instr_t d);
        exp_t       e;
        bit         fault = 0;
        logic [3:0] cause = 0;
        for (int c = 0; c < FT; c++) begin
            cyc_begin();
            set_flags(d);
            e = idle_exp();
            e.req = 1'b1;
            if (c == d.ack_dly) begin
                imem_ack = 1; imem_err = d.ack_err;
                e.iwe = !d.ack_err;
                exp_q.push_back(e);
                if (d.ack_err) begin fault = 1; cause = 4'd1; end
                break;
            end
            exp_q.push_back(e);
            if (c == FT - 1) begin fault = 1; cause = 4'd1; end
        end
        if (!fault) begin
            cyc_begin();
            set_flags(d);
            e = idle_exp();
            e.lreq = d.ld | d.st;
            exp_q.push_back(e);
            if (d.ld | d.st) begin
                for (int c = 0; c <= d.lsu_dly; c++) begin
                    if (d.abort_mem > 0 && c == d.abort_mem) return;
                    cyc_begin();
                    set_flags(d);
                    exp_q.push_back(idle_exp());
                    if (c == d.lsu_dly) begin
                        lsu_done = 1; lsu_err = d.lsu_err;
                        if (d.lsu_err) begin fault = 1; cause = d.st ? 4'd6 : 4'd4; end
                    end
                end
            end
        end
        cyc_begin();
        set_flags(d);
        e = idle_exp();
        if (fault) begin
            e.pcwe = 1; e.psel = 2'b01; e.twe = 1; e.cause = cause;
        end else begin
            if (d.ecall) begin
                e.pcwe = 1; e.psel = 2'b01; e.twe = 1; e.cause = 4'd11;
            end else if (d.ebreak) begin
                e.rfwe = d.wrd;
            end else begin
                e.pcwe = 1; e.rfwe = d.wrd;
                if (d.mret) e.psel = 2'b11;
                else if (d.jalr) e.asel = 2'b11;
                else if (d.jal || (d.br && d.tk)) e.asel = 2'b01;
            end
            m_ir = m_ir + 1;
        end
        exp_q.push_back(e);
    endtask

    initial begin
        instr_t d;
        int     base;
        do_reset(3);
        lit(L_REQ, 0, 0, "req_in_reset");
        lit(L_REQ, 1, 1, "req_after_reset");
        lit(L_INSTRET, 0, 1, "instret_after_reset");

        d = nop(); d.wrd = 1; run(d);
        lit(L_PCWE_CYC, 3, 0, "add_commit_cycle");
        lit(L_INSTRET, 1, 1, "add_retired");

        base = cnt_req;
        d = nop(); d.jalr = 1; d.wrd = 1; d.ack_dly = 3; run(d);
        lit(L_REQ_CNT, 64'(base + 4), 0, "jalr_req_cycles");

        d = nop(); d.br = 1; run(d);
        d = nop(); d.br = 1; d.tk = 1; d.ack_dly = 1; run(d);
        d = nop(); d.jal = 1; d.wrd = 1; run(d);

        base = cnt_lsu;
        d = nop(); d.ld = 1; d.wrd = 1; d.lsu_dly = 5; d.lsu_err = 1; run(d);
        lit(L_LSU_CNT, 64'(base + 1), 0, "load_lsu_pulses");
        lit(L_CAUSE, 4, 0, "load_fault_cause");
        lit(L_INSTRET, 5, 1, "load_fault_no_retire");

        d = nop(); d.st = 1; d.lsu_dly = 2; run(d);
        d = nop(); d.st = 1; d.lsu_err = 1; run(d);
        lit(L_CAUSE, 6, 0, "store_fault_cause");

        d = nop(); d.wrd = 1; d.ack_dly = 2; d.ack_err = 1; run(d);
        d = nop(); d.ecall = 1; run(d);
        lit(L_CAUSE, 11, 0, "ecall_cause");
        lit(L_INSTRET, 7, 1, "ecall_retired");

        base = cnt_req;
        d = nop(); d.ack_dly = -1; run(d);
        lit(L_REQ_CNT, 64'(base + FT), 0, "timeout_req_cycles");
        lit(L_CAUSE, 1, 0, "timeout_cause");

        d = nop(); d.mret = 1; run(d);
        d = nop(); d.wrd = 1; d.ack_dly = FT - 1; run(d);
        lit(L_INSTRET, 9, 1, "ack_at_timeout_retired");

        d = nop(); d.ld = 1; d.wrd = 1; d.lsu_dly = 10; d.abort_mem = 2; run(d);
        do_reset(2);
        lit(L_REQ, 1, 1, "req_after_mid_reset");
        lit(L_INSTRET, 0, 1, "instret_after_mid_reset");

        d = nop(); d.wrd = 1; run(d);
        d = nop(); d.ebreak = 1; run(d);
        halt_cycles(20);
        lit(L_HALTED, 1, 0, "halted_after_20");
        lit(L_INSTRET, 2, 0, "ebreak_retired");

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
